multicycle_ctrl: RTL and testbench
==================================

// Module: multicycle_ctrl
// PURPOSE
//  Main control FSM of the multicycle MIPS core; sequences the shared ALU, register file,
//  instruction register (IR), PC and unified memory port for each instruction.
//  Decodes op[5:0] and issues per-cycle enables and mux selects.
//  Produces aluop[1:0] for the ALU decoder, which turns funct into alucontrol.
//  Waits on a memory ready handshake, so variable-latency memory is supported.
// PARAMETERS
//  RESET_PC_EN  1'b1  1: pcen is held 0 during reset and in the first FETCH cycle after reset release
// PORTS
//  clk          in   1  core clock; all state updates on rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  op           in   6  instr[31:26]; sampled in DECODE only
//  zero         in   1  ALU zero flag; sampled in BEQEX
//  mem_ready    in   1  memory completes the current access this cycle
//  mem_req      out  1  memory access active (FETCH, MEMRD, MEMWR)
//  memwrite     out  1  write strobe to memory
//  irwrite      out  1  load IR from memory read data
//  iord         out  1  memory address mux: 0 = PC, 1 = ALUOut
//  pcen         out  1  PC load enable = pcwrite | (branch & branch_taken)
//  pcsrc        out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
//  alusrca      out  1  ALU A mux: 0 = PC, 1 = A register
//  alusrcb      out  2  ALU B mux: 00 = B, 01 = const 4, 10 = SignImm, 11 = SignImm<<2
//  aluop        out  2  00 = add, 01 = sub, 10 = decode funct
//  regwrite     out  1  register file write enable
//  regdst       out  1  write-register mux: 0 = rt, 1 = rd
//  memtoreg     out  1  write-data mux: 0 = ALUOut, 1 = memory data
//  illegal      out  1  one-cycle pulse: unsupported op seen in DECODE
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  Moore FSM. Outputs are decoded from state only, except handshake gating noted below.
//  State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6,
//   RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11. Codes 12-15 go to FETCH on the next edge.
//  Reset (reset_n=0, asynchronous): state=FETCH.
//   All enables forced 0: mem_req, memwrite, irwrite, pcen, regwrite.
//   All selects 0; aluop=00; illegal=0.
//  FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
//   Stays in FETCH while mem_ready=0.
//   irwrite and pcen are 1 only in the cycle mem_ready=1; then go to DECODE.
//  DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
//   100011 lw / 101011 sw -> MEMADR; 000000 R-type -> RTYPEEX; 000100 beq -> BEQEX;
//   001000 addi -> ADDIEX; 000010 j -> JEX.
//   Any other op -> FETCH, with illegal=1 for this cycle.
//  MEMADR: alusrca=1, alusrcb=10, aluop=00. Next: MEMRD for lw, MEMWR for sw.
//  MEMRD: mem_req=1, iord=1. Holds until mem_ready=1, then -> MEMWB.
//  MEMWB: regwrite=1, regdst=0, memtoreg=1. Next: FETCH.
//  MEMWR: mem_req=1, iord=1, memwrite=1 every cycle in the state. Holds until mem_ready=1, then -> FETCH.
//  RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Next: RTYPEWB.
//  RTYPEWB: regwrite=1, regdst=1, memtoreg=0. Next: FETCH.
//  BEQEX: alusrca=1, alusrcb=00, aluop=01, pcsrc=01, branch=1; branch_taken=zero. Next: FETCH.
//  ADDIEX: alusrca=1, alusrcb=10, aluop=00. Next: ADDIWB.
//  ADDIWB: regwrite=1, regdst=0, memtoreg=0. Next: FETCH.
//  JEX: pcsrc=10, pcen=1. Next: FETCH.
//  Latencies (zero memory wait):
//   lw 5 cycles; sw 4; R-type 4; addi 4; beq 3; j 3. Each memory wait cycle adds 1.
//  op changes outside DECODE are ignored; the op captured in DECODE steers MEMADR.
//   The MEMADR lw/sw choice is held in a 1-bit flag.
//  reset_n asserted mid-instruction: immediate return to FETCH; no partial write
//   (regwrite/memwrite drop asynchronously).
//  If mem_ready is high in a non-memory state, it is ignored.
// CONFIGURATION
//  BNE_EN defined: op 000101 (bne) -> BEQEX with branch_taken = ~zero.
//   The captured flag selects polarity; bne latency 3 cycles.
//  BNE_EN undefined: op 000101 is illegal -> FETCH with illegal pulse.
// TESTING
//  1. reset_n=0 mid-MEMWR (memwrite=1) -> memwrite=0 immediately; after release state_dbg=0, pcen=0.
//  2. lw, mem_ready=1 always -> states 0,1,2,3,4,0; regwrite=1 only in state 4 with memtoreg=1.
//  3. sw, mem_ready low 3 cycles in MEMWR -> memwrite=1 for 4 cycles; single transition to FETCH.
//  4. beq: zero=1 -> pcen=1, pcsrc=01 in BEQEX; zero=0 -> pcen=0. Latency 3 either way.
//  5. R-type then addi -> RTYPEWB regdst=1, aluop=10 in EX; ADDIWB regdst=0, alusrcb=10 in EX.
//  6. op=000101 -> BNE_EN on: branch when zero=0; BNE_EN off: illegal=1 in DECODE, then state_dbg=0.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Control/handshake bundle between the multicycle MIPS control
//                FSM (master) and the datapath + memory port (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if;
  logic [5:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       memwrite;
  logic       irwrite;
  logic       iord;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] aluop;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       illegal;
  logic [3:0] state_dbg;

  // Control FSM side: samples opcode/flags, drives enables and selects
  modport master (
    input  op, zero, mem_ready,
    output mem_req, memwrite, irwrite, iord, pcen, pcsrc, alusrca, alusrcb,
           aluop, regwrite, regdst, memtoreg, illegal, state_dbg
  );

  // Datapath side: supplies opcode/flags, consumes controls
  modport slave (
    output op, zero, mem_ready,
    input  mem_req, memwrite, irwrite, iord, pcen, pcsrc, alusrca, alusrcb,
           aluop, regwrite, regdst, memtoreg, illegal, state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Main control FSM of the multicycle MIPS core. Sequences ALU,
//                register file, IR, PC and the unified memory port, waiting
//                on mem_ready for variable-latency memory.
//  Options     : define BNE_EN to accept bne (op 000101) as an inverted beq.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter logic RESET_PC_EN = 1'b1
) (
  input  wire logic          clk,
  input  wire logic          reset_n,
  multicycle_ctrl_if.master  bus
);

  localparam logic [3:0] c_ST_FETCH   = 4'd0;
  localparam logic [3:0] c_ST_DECODE  = 4'd1;
  localparam logic [3:0] c_ST_MEMADR  = 4'd2;
  localparam logic [3:0] c_ST_MEMRD   = 4'd3;
  localparam logic [3:0] c_ST_MEMWB   = 4'd4;
  localparam logic [3:0] c_ST_MEMWR   = 4'd5;
  localparam logic [3:0] c_ST_RTYPEEX = 4'd6;
  localparam logic [3:0] c_ST_RTYPEWB = 4'd7;
  localparam logic [3:0] c_ST_BEQEX   = 4'd8;
  localparam logic [3:0] c_ST_ADDIEX  = 4'd9;
  localparam logic [3:0] c_ST_ADDIWB  = 4'd10;
  localparam logic [3:0] c_ST_JEX     = 4'd11;

  localparam logic [5:0] c_OP_RTYPE = 6'b000000;
  localparam logic [5:0] c_OP_J     = 6'b000010;
  localparam logic [5:0] c_OP_BEQ   = 6'b000100;
  localparam logic [5:0] c_OP_ADDI  = 6'b001000;
  localparam logic [5:0] c_OP_LW    = 6'b100011;
  localparam logic [5:0] c_OP_SW    = 6'b101011;
`ifdef BNE_EN
  localparam logic [5:0] c_OP_BNE   = 6'b000101;
`endif

  logic [3:0] state_q, state_d;
  logic       is_sw_q, is_sw_d;   // lw/sw choice taken in DECODE, used by MEMADR
  logic       first_q;            // high in the first cycle after reset release
`ifdef BNE_EN
  logic       inv_q, inv_d;       // branch polarity: 1 = bne (taken on ~zero)
`endif

  logic       w_op_legal;
  logic       w_pcwrite;
  logic       w_branch;
  logic       w_taken;

  // State and captured-instruction registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_ST_FETCH;
      is_sw_q <= 1'b0;
      first_q <= 1'b1;
`ifdef BNE_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      is_sw_q <= is_sw_d;
      first_q <= 1'b0;
`ifdef BNE_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // Opcode legality check used for the illegal pulse in DECODE
  always_comb begin
    w_op_legal = 1'b0;
    case (bus.op)
      c_OP_LW, c_OP_SW, c_OP_RTYPE, c_OP_BEQ, c_OP_ADDI, c_OP_J: w_op_legal = 1'b1;
`ifdef BNE_EN
      c_OP_BNE: w_op_legal = 1'b1;
`endif
      default: w_op_legal = 1'b0;
    endcase
  end

  // Next-state logic; opcode is only looked at in DECODE
  always_comb begin
    state_d = state_q;
    is_sw_d = is_sw_q;
`ifdef BNE_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      c_ST_FETCH:  if (bus.mem_ready) state_d = c_ST_DECODE;
      c_ST_DECODE: begin
        case (bus.op)
          c_OP_LW:    begin state_d = c_ST_MEMADR; is_sw_d = 1'b0; end
          c_OP_SW:    begin state_d = c_ST_MEMADR; is_sw_d = 1'b1; end
          c_OP_RTYPE: state_d = c_ST_RTYPEEX;
          c_OP_ADDI:  state_d = c_ST_ADDIEX;
          c_OP_J:     state_d = c_ST_JEX;
`ifdef BNE_EN
          c_OP_BEQ:   begin state_d = c_ST_BEQEX; inv_d = 1'b0; end
          c_OP_BNE:   begin state_d = c_ST_BEQEX; inv_d = 1'b1; end
`else
          c_OP_BEQ:   state_d = c_ST_BEQEX;
`endif
          default:    state_d = c_ST_FETCH;
        endcase
      end
      c_ST_MEMADR:  state_d = is_sw_q ? c_ST_MEMWR : c_ST_MEMRD;
      c_ST_MEMRD:   if (bus.mem_ready) state_d = c_ST_MEMWB;
      c_ST_MEMWB:   state_d = c_ST_FETCH;
      c_ST_MEMWR:   if (bus.mem_ready) state_d = c_ST_FETCH;
      c_ST_RTYPEEX: state_d = c_ST_RTYPEWB;
      c_ST_RTYPEWB: state_d = c_ST_FETCH;
      c_ST_BEQEX:   state_d = c_ST_FETCH;
      c_ST_ADDIEX:  state_d = c_ST_ADDIWB;
      c_ST_ADDIWB:  state_d = c_ST_FETCH;
      c_ST_JEX:     state_d = c_ST_FETCH;
      default:      state_d = c_ST_FETCH;
    endcase
  end

  // Output decode; everything is forced low while reset_n is asserted so
  // no write strobe survives an asynchronous reset
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.memwrite  = 1'b0;
    bus.irwrite   = 1'b0;
    bus.iord      = 1'b0;
    bus.pcsrc     = 2'b00;
    bus.alusrca   = 1'b0;
    bus.alusrcb   = 2'b00;
    bus.aluop     = 2'b00;
    bus.regwrite  = 1'b0;
    bus.regdst    = 1'b0;
    bus.memtoreg  = 1'b0;
    bus.illegal   = 1'b0;
    bus.state_dbg = state_q;
    w_pcwrite     = 1'b0;
    w_branch      = 1'b0;
`ifdef BNE_EN
    w_taken       = bus.zero ^ inv_q;
`else
    w_taken       = bus.zero;
`endif
    if (reset_n) begin
      case (state_q)
        c_ST_FETCH: begin
          bus.mem_req = 1'b1;
          bus.alusrcb = 2'b01;
          bus.irwrite = bus.mem_ready;
          w_pcwrite   = bus.mem_ready & ~(RESET_PC_EN & first_q);
        end
        c_ST_DECODE: begin
          bus.alusrcb = 2'b11;
          bus.illegal = ~w_op_legal;
        end
        c_ST_MEMADR: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        c_ST_MEMRD: begin
          bus.mem_req = 1'b1;
          bus.iord    = 1'b1;
        end
        c_ST_MEMWB: begin
          bus.regwrite = 1'b1;
          bus.memtoreg = 1'b1;
        end
        c_ST_MEMWR: begin
          bus.mem_req  = 1'b1;
          bus.iord     = 1'b1;
          bus.memwrite = 1'b1;
        end
        c_ST_RTYPEEX: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 2'b10;
        end
        c_ST_RTYPEWB: begin
          bus.regwrite = 1'b1;
          bus.regdst   = 1'b1;
        end
        c_ST_BEQEX: begin
          bus.alusrca = 1'b1;
          bus.aluop   = 2'b01;
          bus.pcsrc   = 2'b01;
          w_branch    = 1'b1;
        end
        c_ST_ADDIEX: begin
          bus.alusrca = 1'b1;
          bus.alusrcb = 2'b10;
        end
        c_ST_ADDIWB: bus.regwrite = 1'b1;
        c_ST_JEX: begin
          bus.pcsrc = 2'b10;
          w_pcwrite = 1'b1;
        end
        default: ;
      endcase
    end
    bus.pcen = w_pcwrite | (w_branch & w_taken);
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Directed self-checking bench for multicycle_ctrl. Each
//                instruction is expanded into its expected per-cycle state
//                list; a compare process checks every cycle's outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam logic [5:0] c_LW = 6'b100011, c_SW = 6'b101011, c_RT = 6'b000000;
  localparam logic [5:0] c_BEQ = 6'b000100, c_ADDI = 6'b001000, c_J = 6'b000010;
  localparam logic [5:0] c_BNE = 6'b000101, c_JUNK = 6'b111111;
`ifdef BNE_EN
  localparam bit BNE_ON = 1'b1;
`else
  localparam bit BNE_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.RESET_PC_EN(1'b1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] op;
    logic       mr;
    logic       z;
    logic       first;
    logic       inv;
  } exp_t;

  typedef struct packed {
    logic       mem_req, memwrite, irwrite, iord, pcen;
    logic [1:0] pcsrc;
    logic       alusrca;
    logic [1:0] alusrcb, aluop;
    logic       regwrite, regdst, memtoreg, illegal;
  } ctl_t;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  logic pending_release = 1'b0;
  logic first_flag = 1'b0;
  int   n_mw, n_rw, n_pc, n_il, n_busy;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // Control word each state must present, straight from the state table
  function automatic ctl_t model(input exp_t e);
    ctl_t c;
    bit   legal;
    c = '0;
    legal = (e.op inside {c_LW, c_SW, c_RT, c_BEQ, c_ADDI, c_J}) || (BNE_ON && e.op == c_BNE);
    case (e.st)
      4'd0:  begin c.mem_req = 1; c.alusrcb = 2'b01; c.irwrite = e.mr; c.pcen = e.mr && !e.first; end
      4'd1:  begin c.alusrcb = 2'b11; c.illegal = !legal; end
      4'd2:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      4'd3:  begin c.mem_req = 1; c.iord = 1; end
      4'd4:  begin c.regwrite = 1; c.memtoreg = 1; end
      4'd5:  begin c.mem_req = 1; c.iord = 1; c.memwrite = 1; end
      4'd6:  begin c.alusrca = 1; c.aluop = 2'b10; end
      4'd7:  begin c.regwrite = 1; c.regdst = 1; end
      4'd8:  begin c.alusrca = 1; c.aluop = 2'b01; c.pcsrc = 2'b01; c.pcen = e.inv ? !e.z : e.z; end
      4'd9:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
      4'd10: c.regwrite = 1;
      4'd11: begin c.pcsrc = 2'b10; c.pcen = 1; end
      default: ;
    endcase
    return c;
  endfunction

  exp_t ce;
  ctl_t cm;

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      ce = exp_q.pop_front();
      cm = model(ce);
      check("state_dbg", int'(bus.state_dbg), int'(ce.st));
      check("mem_req",   int'(bus.mem_req),   int'(cm.mem_req));
      check("memwrite",  int'(bus.memwrite),  int'(cm.memwrite));
      check("irwrite",   int'(bus.irwrite),   int'(cm.irwrite));
      check("iord",      int'(bus.iord),      int'(cm.iord));
      check("pcen",      int'(bus.pcen),      int'(cm.pcen));
      check("pcsrc",     int'(bus.pcsrc),     int'(cm.pcsrc));
      check("alusrca",   int'(bus.alusrca),   int'(cm.alusrca));
      check("alusrcb",   int'(bus.alusrcb),   int'(cm.alusrcb));
      check("aluop",     int'(bus.aluop),     int'(cm.aluop));
      check("regwrite",  int'(bus.regwrite),  int'(cm.regwrite));
      check("regdst",    int'(bus.regdst),    int'(cm.regdst));
      check("memtoreg",  int'(bus.memtoreg),  int'(cm.memtoreg));
      check("illegal",   int'(bus.illegal),   int'(cm.illegal));
    end
  end

  // Event counters observed on the DUT, pinned to literal values per test
  always @(negedge clk) begin
    if (bus.memwrite) n_mw++;
    if (bus.regwrite) n_rw++;
    if (bus.pcen)     n_pc++;
    if (bus.illegal)  n_il++;
    if (bus.state_dbg != 4'd0) n_busy++;
  end

  task automatic clear_counts();
    n_mw = 0; n_rw = 0; n_pc = 0; n_il = 0; n_busy = 0;
  endtask

  task automatic cycle(input logic [3:0] st, input logic [5:0] op,
                       input logic mr, input logic z, input logic inv);
    exp_t e;
    @(posedge clk);
    #1;
    if (pending_release) begin
      reset_n = 1'b1;
      pending_release = 1'b0;
      first_flag = 1'b1;
    end
    bus.op = op;
    bus.mem_ready = mr;
    bus.zero = z;
    e.st = st; e.op = op; e.mr = mr; e.z = z; e.first = first_flag; e.inv = inv;
    first_flag = 1'b0;
    exp_q.push_back(e);
  endtask

  // Expand one instruction into its cycle list; fw/mw are memory wait cycles
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) cycle(4'd0, c_JUNK, 1'b0, ~z, 1'b0);
    cycle(4'd0, c_JUNK, 1'b1, ~z, 1'b0);
    cycle(4'd1, op, 1'b1, ~z, 1'b0);
    case (op)
      c_LW: begin
        cycle(4'd2, c_JUNK, 1'b1, ~z, 1'b0);
        for (int i = 0; i < mw; i++) cycle(4'd3, c_JUNK, 1'b0, ~z, 1'b0);
        cycle(4'd3, c_JUNK, 1'b1, ~z, 1'b0);
        cycle(4'd4, c_JUNK, 1'b1, ~z, 1'b0);
      end
      c_SW: begin
        cycle(4'd2, c_SW, 1'b1, ~z, 1'b0);
        for (int i = 0; i < mw; i++) cycle(4'd5, c_LW, 1'b0, ~z, 1'b0);
        cycle(4'd5, c_JUNK, 1'b1, ~z, 1'b0);
      end
      c_RT:   begin cycle(4'd6, c_JUNK, 1'b1, ~z, 1'b0); cycle(4'd7, c_JUNK, 1'b1, ~z, 1'b0); end
      c_ADDI: begin cycle(4'd9, c_JUNK, 1'b1, ~z, 1'b0); cycle(4'd10, c_JUNK, 1'b1, ~z, 1'b0); end
      c_BEQ:  cycle(4'd8, c_JUNK, 1'b1, z, 1'b0);
      c_J:    cycle(4'd11, c_JUNK, 1'b1, ~z, 1'b0);
      c_BNE:  if (BNE_ON) cycle(4'd8, c_JUNK, 1'b1, z, 1'b1);
      default: ;
    endcase
    @(negedge clk);
    #1;
  endtask

  initial begin
    bus.op = 6'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    clear_counts();

    // Reset state: all enables low although FETCH would request memory
    repeat (2) @(negedge clk);
    check("rst_state",    int'(bus.state_dbg), 0);
    check("rst_mem_req",  int'(bus.mem_req),   0);
    check("rst_pcen",     int'(bus.pcen),      0);
    check("rst_irwrite",  int'(bus.irwrite),   0);
    pending_release = 1'b1;

    // lw right after reset: first FETCH keeps pcen low
    clear_counts(); run_instr(c_LW, 0, 0, 1'b0);
    check("lw0_pcen_cnt", n_pc, 0);
    check("lw0_rw_cnt",   n_rw, 1);
    check("lw0_busy",     n_busy, 4);

    clear_counts(); run_instr(c_LW, 2, 2, 1'b1);
    check("lw_wait_pcen", n_pc, 1);
    check("lw_wait_rw",   n_rw, 1);

    clear_counts(); run_instr(c_SW, 0, 3, 1'b0);
    check("sw_mw_cnt",   n_mw, 4);
    check("sw_busy",     n_busy, 6);

    clear_counts(); run_instr(c_BEQ, 0, 0, 1'b1);
    check("beq_t_pcen",  n_pc, 2);
    check("beq_t_busy",  n_busy, 2);
    clear_counts(); run_instr(c_BEQ, 1, 0, 1'b0);
    check("beq_nt_pcen", n_pc, 1);

    clear_counts(); run_instr(c_RT, 0, 0, 1'b0);
    check("rt_rw_cnt",   n_rw, 1);
    clear_counts(); run_instr(c_ADDI, 0, 0, 1'b1);
    check("addi_rw_cnt", n_rw, 1);

    clear_counts(); run_instr(c_J, 0, 0, 1'b0);
    check("j_pcen",      n_pc, 2);
    check("j_busy",      n_busy, 2);

    clear_counts(); run_instr(c_BNE, 0, 0, 1'b0);
    check("bne_z0_pcen", n_pc, BNE_ON ? 2 : 1);
    check("bne_z0_ill",  n_il, BNE_ON ? 0 : 1);
    clear_counts(); run_instr(c_BNE, 0, 0, 1'b1);
    check("bne_z1_pcen", n_pc, 1);

    clear_counts(); run_instr(c_JUNK, 0, 0, 1'b0);
    check("bad_op_ill",  n_il, 1);
    check("bad_op_busy", n_busy, 1);

    // Reset asserted in the middle of a store
    cycle(4'd0, c_JUNK, 1'b1, 1'b0, 1'b0);
    cycle(4'd1, c_SW,   1'b1, 1'b0, 1'b0);
    cycle(4'd2, c_JUNK, 1'b0, 1'b0, 1'b0);
    cycle(4'd5, c_JUNK, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    check("pre_rst_memwrite", int'(bus.memwrite), 1);
    reset_n = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    check("mid_rst_memwrite", int'(bus.memwrite),  0);
    check("mid_rst_mem_req",  int'(bus.mem_req),   0);
    check("mid_rst_state",    int'(bus.state_dbg), 0);
    check("mid_rst_pcen",     int'(bus.pcen),      0);
    @(negedge clk);
    pending_release = 1'b1;
    clear_counts(); run_instr(c_LW, 0, 1, 1'b0);
    check("post_rst_pcen", n_pc, 0);
    check("post_rst_rw",   n_rw, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
